// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider; DIV_SIGNED_EN selects two's-complement operation
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_Load_Clr,
    input  logic             run_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             sign_LED,
    output logic             busy_o,
    output logic             div0_o,
    output logic             ovf_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             div0_path;

    logic [WIDTH-1:0] dvd_mag_c;
    logic [WIDTH-1:0] dvs_mag_c;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             last_iter;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;
    logic ovf_path;

    assign dvd_mag_c = Bval[WIDTH-1] ? (~Bval + 1'b1) : Bval;
    assign dvs_mag_c = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
    assign quo_fix   = q_neg ? (~quo + 1'b1) : quo;
    assign rem_fix   = r_neg ? (~rem + 1'b1) : rem;
`else
    assign dvd_mag_c = Bval;
    assign dvs_mag_c = divisor;
    assign quo_fix   = quo;
    assign rem_fix   = rem;
    assign sign_LED  = 1'b0;
    assign ovf_o     = 1'b0;
`endif

    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits
    // and the borrow bit of the trial subtraction decides restore vs keep.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_mag};
    assign last_iter = (count == CW'(WIDTH - 1));
    assign busy_o    = (state == PREP) || (state == ITER) || (state == FIX);

    always_ff @(posedge Clk) begin
        if (Reset_Load_Clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run_i) state_next = PREP;
            PREP:    state_next = (divisor == '0) ? FIX : ITER;
            ITER:    if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (!run_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_Load_Clr) begin
            Aval      <= '0;
            Bval      <= sw_i;
            div0_o    <= 1'b0;
            count     <= '0;
            divisor   <= '0;
            dvs_mag   <= '0;
            quo       <= '0;
            rem       <= '0;
            div0_path <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_LED  <= 1'b0;
            ovf_o     <= 1'b0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_path  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (run_i) divisor <= sw_i;
                end
                PREP: begin
                    rem       <= '0;
                    quo       <= dvd_mag_c;
                    dvs_mag   <= dvs_mag_c;
                    count     <= '0;
                    div0_o    <= 1'b0;
                    div0_path <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                    ovf_o     <= 1'b0;
                    q_neg     <= Bval[WIDTH-1] ^ divisor[WIDTH-1];
                    r_neg     <= Bval[WIDTH-1];
                    ovf_path  <= (Bval == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`endif
                end
                ITER: begin
                    quo   <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    rem   <= trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
                    count <= last_iter ? '0 : count + 1'b1;
                end
                FIX: begin
                    if (div0_path) begin
                        Bval     <= '1;
                        Aval     <= Bval;
                        div0_o   <= 1'b1;
`ifdef DIV_SIGNED_EN
                        sign_LED <= 1'b0;
`endif
                    end else begin
                        Bval     <= quo_fix;
                        Aval     <= rem_fix;
`ifdef DIV_SIGNED_EN
                        // most-negative / -1 wraps back to itself; still flagged negative
                        sign_LED <= q_neg | ovf_path;
                        ovf_o    <= ovf_path;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - vector table plus scoreboard bench for seq_divider
module tb_seq_divider;

    logic       Clk;
    logic       Reset_Load_Clr;
    logic       run_i;
    logic [7:0] sw_i;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       sign_LED;
    logic       busy_o;
    logic       div0_o;
    logic       ovf_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       load;
        logic [7:0] ld;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       sgn;
        logic       d0;
        logic       ov;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       sgn;
        logic       d0;
        logic       ov;
    } exp_t;

    vec_t vt[10];
    exp_t sb[$];

    seq_divider #(.WIDTH(8)) dut (
        .Clk            (Clk),
        .Reset_Load_Clr (Reset_Load_Clr),
        .run_i          (run_i),
        .sw_i           (sw_i),
        .Aval           (Aval),
        .Bval           (Bval),
        .sign_LED       (sign_LED),
        .busy_o         (busy_o),
        .div0_o         (div0_o),
        .ovf_o          (ovf_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge Clk);
        Reset_Load_Clr = 1'b1;
        run_i          = 1'b0;
        sw_i           = v;
        @(negedge Clk);
        Reset_Load_Clr = 1'b0;
    endtask

    // Starts a division, pokes run_i/sw_i while busy, then checks latency,
    // held outputs and the result popped from the scoreboard.
    task automatic do_run(input logic [7:0] dvs, input exp_t e);
        exp_t       got;
        int         k;
        int         lat;
        logic [7:0] old_a;
        logic [7:0] old_b;
        lat   = e.d0 ? 2 : 10;
        run_i = 1'b0;
        @(negedge Clk);
        old_a = Aval;
        old_b = Bval;
        sw_i  = dvs;
        run_i = 1'b1;
        sb.push_back(e);
        @(negedge Clk);
        run_i = 1'b0;
        sw_i  = ~dvs;
        k     = 0;
        while (busy_o && k < 40) begin
            if (k == lat - 1) begin
                chk("hold_b", Bval, old_b);
                chk("hold_a", Aval, old_a);
            end
            if (k == 3) run_i = 1'b1;
            if (k == 5) run_i = 1'b0;
            @(negedge Clk);
            k++;
        end
        run_i = 1'b0;
        chk("latency", k, lat);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("quot", Bval, got.q);
            chk("rem", Aval, got.r);
            chk("sign", sign_LED, got.sgn);
            chk("div0", div0_o, got.d0);
            chk("ovf", ovf_o, got.ov);
        end
    endtask

    initial begin
        exp_t e;
        int   starts;
        logic prev;
        int   dd;
        int   dv;

`ifdef DIV_SIGNED_EN
        vt[0] = '{1'b1, 8'hC5, 8'h07, 8'hF8, 8'hFD, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 8'h02, 8'hFC, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 8'h64, 8'h03, 8'h21, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 8'h9C, 8'hFD, 8'h21, 8'hFF, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'h81, 8'h7F, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
`else
        vt[0] = '{1'b1, 8'hC5, 8'h07, 8'h1C, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 8'h02, 8'h0E, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 8'h64, 8'h03, 8'h21, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 8'h9C, 8'hFD, 8'h00, 8'h9C, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'h81, 8'h7F, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 8'h00, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
`endif
        vt[8] = '{1'b1, 8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[9] = '{1'b1, 8'h05, 8'h0A, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0};

        Reset_Load_Clr = 1'b1;
        run_i          = 1'b0;
        sw_i           = 8'h00;
        repeat (2) @(negedge Clk);
        load(8'h5A);
        chk("rst_a", Aval, 8'h00);
        chk("rst_b", Bval, 8'h5A);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sign", sign_LED, 1'b0);
        chk("rst_div0", div0_o, 1'b0);
        chk("rst_ovf", ovf_o, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (vt[i].load) load(vt[i].ld);
            e = '{vt[i].q, vt[i].r, vt[i].sgn, vt[i].d0, vt[i].ov};
            do_run(vt[i].dvs, e);
        end

        // Non-negative operands below 0x80 mean the same in both builds.
        for (int i = 0; i < 6; i++) begin
            dd = $urandom_range(0, 127);
            dv = $urandom_range(1, 127);
            load(8'(dd));
            e = '{8'(dd / dv), 8'(dd % dv), 1'b0, 1'b0, 1'b0};
            do_run(8'(dv), e);
        end

        // Reset in the 4th ITER cycle aborts and reloads.
        load(8'hC5);
        @(negedge Clk);
        sw_i  = 8'h07;
        run_i = 1'b1;
        @(negedge Clk);
        run_i = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_Load_Clr = 1'b1;
        sw_i           = 8'h10;
        @(negedge Clk);
        Reset_Load_Clr = 1'b0;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_a", Aval, 8'h00);
        chk("abort_b", Bval, 8'h10);
        e = '{8'h04, 8'h00, 1'b0, 1'b0, 1'b0};
        do_run(8'h04, e);

        // Reset wins over run on the same edge.
        load(8'h11);
        @(negedge Clk);
        Reset_Load_Clr = 1'b1;
        run_i          = 1'b1;
        sw_i           = 8'h33;
        @(negedge Clk);
        Reset_Load_Clr = 1'b0;
        run_i          = 1'b0;
        chk("prio_busy", busy_o, 1'b0);
        chk("prio_b", Bval, 8'h33);
        @(negedge Clk);
        chk("prio_idle", busy_o, 1'b0);

        // Held run gives exactly one division.
        load(8'h64);
        @(negedge Clk);
        sw_i   = 8'h03;
        run_i  = 1'b1;
        starts = 0;
        prev   = busy_o;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (busy_o && !prev) starts++;
            prev = busy_o;
        end
        chk("held_starts", starts, 1);
        chk("held_b", Bval, 8'h21);
        chk("held_a", Aval, 8'h01);
        run_i = 1'b0;
        @(negedge Clk);
        e = '{8'h0B, 8'h00, 1'b0, 1'b0, 1'b0};
        do_run(8'h03, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
